// File: rtl/lfsr_pkg.sv
// lfsr_pkg: state encodings and the tap law shared by the lfsr generator and prbs_checker
package lfsr_pkg;

    localparam int MAX_N = 32;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Mask selecting stages N and TAP of a history vector whose bit 0 is the newest bit
    function automatic logic [MAX_N-1:0] lfsr_tap_mask(input int n, input int tap);
        return (MAX_N'(1) << (n - 1)) | (MAX_N'(1) << (tap - 1));
    endfunction

    // Next stream bit predicted from history: XOR of the two feedback stages
    function automatic logic lfsr_next_bit(input logic [MAX_N-1:0] h, input logic [MAX_N-1:0] tap_mask);
        return ^(h & tap_mask);
    endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear that still counts the same-cycle event
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] cnt_d;

    // Clear first, then add this cycle's event unless already at full scale
    always_comb begin
        base  = clr_i ? '0 : cnt_q;
        cnt_d = (inc_i && base != '1) ? base + CNT_W'(1) : base;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker with lock detection and saturating error/bit counters
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int N           = 3,
    parameter int TAP         = 2,
    parameter int LOCK_CNT    = 4,
    parameter int LOSS_THRESH = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [MAX_N-1:0] TAP_MASK = lfsr_tap_mask(N, TAP);
    localparam int SW = $clog2(N + 1);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_THRESH + 1);

    state_e         state_q;
    logic [N-1:0]   h_q;
    logic [SW-1:0]  seed_q;
    logic [RW-1:0]  run_q;
    logic [MW-1:0]  miss_q;
    logic           locked_q;
    logic           err_pulse_q;

    logic           pred;
    logic           mis;
    logic [N-1:0]   h_din;
    logic [N-1:0]   h_fly;
    logic           bit_ev;
    logic           err_ev;

    // Prediction from history; in LOCKED the history flywheels on its own prediction
    always_comb begin
        pred   = lfsr_next_bit(MAX_N'(h_q), TAP_MASK);
        mis    = din ^ pred;
        h_din  = {h_q[N-2:0], din};
        h_fly  = {h_q[N-2:0], pred};
        bit_ev = din_valid && state_q == ST_LOCKED;
        err_ev = bit_ev && mis;
    end

    // Seed / verify / locked sequencing with registered lock and error-pulse outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_SEED;
            h_q         <= '0;
            seed_q      <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (din_valid) begin
                case (state_q)
                    ST_SEED: begin
                        h_q <= h_din;
                        if (seed_q == SW'(N - 1)) begin
                            seed_q <= '0;
                            if (h_din != '0) begin
                                state_q <= ST_VERIFY;
                                run_q   <= '0;
                            end
                        end else begin
                            seed_q <= seed_q + SW'(1);
                        end
                    end
                    ST_VERIFY: begin
                        h_q <= h_din;
                        if (mis) begin
                            state_q <= ST_SEED;
                            seed_q  <= '0;
                        end else if (run_q == RW'(LOCK_CNT - 1)) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                            miss_q   <= '0;
                        end else begin
                            run_q <= run_q + RW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        h_q <= h_fly;
                        if (mis) begin
                            err_pulse_q <= 1'b1;
                            if (miss_q == MW'(LOSS_THRESH - 1)) begin
                                state_q  <= ST_SEED;
                                seed_q   <= '0;
                                locked_q <= 1'b0;
                            end else begin
                                miss_q <= miss_q + MW'(1);
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end
                    default: begin
                        state_q  <= ST_SEED;
                        seed_q   <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr_cnt),
        .inc_i   (err_ev),
        .cnt_o   (err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (clr_cnt),
        .inc_i   (bit_ev),
        .cnt_o   (bit_cnt)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: vector table, directed corner sequences and randomized stimulus against a queue-based reference model
module tb_prbs_checker;

    localparam int N = 3, TAP = 2, LOCK_CNT = 4, LOSS_THRESH = 3, CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0, din_valid = 1'b0, din = 1'b0, clr_cnt = 1'b0;
    logic locked, err_pulse;
    logic [CNT_W-1:0] err_cnt, bit_cnt;

    prbs_checker #(.N(N), .TAP(TAP), .LOCK_CNT(LOCK_CNT), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din_valid (din_valid),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Reference stream 1,0,0,1,0,1,1 (x^3+x+1), walked by index
    bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int si = 0;

    function automatic bit nb();
        bit b = pat[si % 7];
        si++;
        return b;
    endfunction

    // Reference model: phase name, bit history (index 0 newest), counts as plain ints
    int  m_phase;
    bit  hist[$];
    int  m_seed, m_run, m_miss, m_err, m_bits;
    bit  m_pulse;

    task automatic model(bit rn, bit v, bit d, bit c);
        bit pred, ev_err, ev_bit;
        bit allz;
        ev_err = 0;
        ev_bit = 0;
        m_pulse = 0;
        if (!rn) begin
            m_phase = 0; m_seed = 0; m_run = 0; m_miss = 0; m_err = 0; m_bits = 0;
            hist = {};
            for (int i = 0; i < N; i++) hist.push_back(1'b0);
            return;
        end
        if (v) begin
            pred = hist[N-1] ^ hist[TAP-1];
            if (m_phase == 0) begin
                hist.push_front(d); void'(hist.pop_back());
                m_seed++;
                if (m_seed == N) begin
                    m_seed = 0;
                    allz = 1;
                    foreach (hist[i]) if (hist[i]) allz = 0;
                    if (!allz) begin m_phase = 1; m_run = 0; end
                end
            end else if (m_phase == 1) begin
                hist.push_front(d); void'(hist.pop_back());
                if (d == pred) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin m_phase = 2; m_miss = 0; end
                end else begin
                    m_phase = 0; m_seed = 0;
                end
            end else begin
                hist.push_front(pred); void'(hist.pop_back());
                ev_bit = 1;
                if (d != pred) begin
                    ev_err = 1; m_pulse = 1; m_miss++;
                    if (m_miss == LOSS_THRESH) begin m_phase = 0; m_seed = 0; end
                end else m_miss = 0;
            end
        end
        if (c) begin m_err = 0; m_bits = 0; end
        if (ev_err && m_err < CMAX) m_err++;
        if (ev_bit && m_bits < CMAX) m_bits++;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one cycle, sample 1 ns after the edge, compare all outputs with the model
    task automatic step(bit rn, bit v, bit d, bit c);
        reset_n = rn; din_valid = v; din = d; clr_cnt = c;
        @(posedge clk);
        #1;
        model(rn, v, d, c);
        check("locked/model", 32'(locked), 32'(m_phase == 2));
        check("err_pulse/model", 32'(err_pulse), 32'(m_pulse));
        check("err_cnt/model", 32'(err_cnt), 32'(m_err));
        check("bit_cnt/model", 32'(bit_cnt), 32'(m_bits));
    endtask

    task automatic lock_up();
        step(0, 0, 0, 0);
        si = 0;
        for (int i = 0; i < N + LOCK_CNT; i++) step(1, 1, nb(), 0);
        check("lock_after_7", 32'(locked), 1);
    endtask

    typedef struct {
        bit rn, v, d, c;
        bit e_lock, e_pulse;
        int e_err, e_bits;
    } vec_t;

    vec_t vt[$];

    initial begin
        bit b;
        // Test 1 table: reset, 7 bits to lock, then counting starts
        vt.push_back('{0, 1, 1, 1, 0, 0, 0, 0});
        vt.push_back('{1, 1, 1, 0, 0, 0, 0, 0});
        vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1, 1, 1, 0, 0, 0, 0, 0});
        vt.push_back('{1, 1, 0, 0, 0, 0, 0, 0});
        vt.push_back('{1, 1, 1, 0, 0, 0, 0, 0});
        vt.push_back('{1, 1, 1, 0, 1, 0, 0, 0});
        vt.push_back('{1, 1, 1, 0, 1, 0, 0, 1});
        vt.push_back('{1, 0, 0, 0, 1, 0, 0, 1});
        vt.push_back('{1, 1, 0, 0, 1, 0, 0, 2});
        vt.push_back('{1, 1, 0, 0, 1, 0, 0, 3});
        foreach (vt[i]) begin
            step(vt[i].rn, vt[i].v, vt[i].d, vt[i].c);
            check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(vt[i].e_lock));
            check($sformatf("tbl%0d_pulse", i), 32'(err_pulse), 32'(vt[i].e_pulse));
            check($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(vt[i].e_err));
            check($sformatf("tbl%0d_bits", i), 32'(bit_cnt), 32'(vt[i].e_bits));
        end
        si = 10;
        for (int i = 0; i < 17; i++) step(1, 1, nb(), 0);
        check("t1_bit_sat", 32'(bit_cnt), 15);
        check("t1_err_zero", 32'(err_cnt), 0);

        // Test 2: single flipped bit
        step(1, 1, ~nb(), 0);
        check("t2_pulse", 32'(err_pulse), 1);
        check("t2_err1", 32'(err_cnt), 1);
        step(1, 1, nb(), 0);
        check("t2_pulse_once", 32'(err_pulse), 0);
        for (int i = 0; i < 5; i++) step(1, 1, nb(), 0);
        check("t2_err_still1", 32'(err_cnt), 1);
        check("t2_locked", 32'(locked), 1);

        // Test 3: all-zero stream never locks
        step(0, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(1, 1, 0, 0);
        check("t3_unlocked", 32'(locked), 0);
        check("t3_err0", 32'(err_cnt), 0);

        // Test 4: three consecutive errors drop lock, then relock after 7 bits
        lock_up();
        step(1, 1, ~nb(), 0);
        step(1, 1, ~nb(), 0);
        check("t4_hold_after2", 32'(locked), 1);
        step(1, 1, ~nb(), 0);
        check("t4_err3", 32'(err_cnt), 3);
        check("t4_lost", 32'(locked), 0);
        for (int i = 0; i < 6; i++) step(1, 1, nb(), 0);
        check("t4_not_yet", 32'(locked), 0);
        step(1, 1, nb(), 0);
        check("t4_relock", 32'(locked), 1);

        // Test 5: valid toggling; lock after 7 valid bits
        step(0, 0, 0, 0);
        si = 0;
        for (int k = 0; k < 14; k++) begin
            if (k % 2 == 0) step(1, 1, nb(), 0);
            else step(1, 0, $urandom_range(0, 1) != 0, 0);
            if (k == 11) check("t5_not_yet", 32'(locked), 0);
            if (k == 12) check("t5_lock", 32'(locked), 1);
        end

        // Test 6: error saturation, clear with coincident error, reset while locked
        lock_up();
        for (int i = 0; i < 20; i++) begin
            step(1, 1, ~nb(), 0);
            step(1, 1, nb(), 0);
            step(1, 1, nb(), 0);
        end
        check("t6_err_sat", 32'(err_cnt), 15);
        check("t6_locked", 32'(locked), 1);
        step(1, 1, ~nb(), 1);
        check("t6_clr_err1", 32'(err_cnt), 1);
        check("t6_clr_bits1", 32'(bit_cnt), 1);
        step(1, 1, nb(), 0);
        step(0, 1, nb(), 1);
        check("t6_rst_locked", 32'(locked), 0);
        check("t6_rst_err", 32'(err_cnt), 0);
        check("t6_rst_bits", 32'(bit_cnt), 0);

        // Randomized: stream with sparse flips, random valid/clear/reset
        si = $urandom_range(0, 6);
        for (int i = 0; i < 1500; i++) begin
            bit v;
            v = $urandom_range(0, 3) != 0;
            b = v ? nb() : 1'b0;
            if (v && $urandom_range(0, 11) == 0) b = ~b;
            if (!v) b = $urandom_range(0, 1) != 0;
            step($urandom_range(0, 299) != 0, v, b, $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
